// File: rtl/cache_refill_if.sv
// Request, memory-bus and BRAM write-port bundle of cache_refill_ctrl.
// fwd_valid/fwd_data exist only when REFILL_EARLY_FWD_EN is defined.
interface cache_refill_if #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 20,
    parameter int WORDS   = 8
);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                     req_valid;
    logic                     req_ready;
    logic [31:0]              req_paddr;
    logic [WAY_W-1:0]         req_way;
    logic                     rd_req;
    logic [31:0]              rd_addr;
    logic [7:0]               rd_len;
    logic                     rd_ack;
    logic                     rd_valid;
    logic [31:0]              rd_data;
    logic [INDEX_W-1:0]       data_addr;
    logic [31:0]              data_din;
    logic [WAYS*WORDS-1:0]    data_we;
    logic [INDEX_W-1:0]       tag_addr;
    logic [INDEX_W-1:0]       vl_addr;
    logic [TAG_W-1:0]         tag_din;
    logic                     vl_din;
    logic [WAYS-1:0]          tag_we;
    logic [WAYS-1:0]          vl_we;
    logic                     refill_done;
    logic                     init_busy;
`ifdef REFILL_EARLY_FWD_EN
    logic                     fwd_valid;
    logic [31:0]              fwd_data;
`endif

    modport master (
        input  req_valid, req_paddr, req_way, rd_ack, rd_valid, rd_data,
        output req_ready, rd_req, rd_addr, rd_len, data_addr, data_din, data_we,
               tag_addr, vl_addr, tag_din, vl_din, tag_we, vl_we, refill_done, init_busy
`ifdef REFILL_EARLY_FWD_EN
               , fwd_valid, fwd_data
`endif
    );

    modport slave (
        output req_valid, req_paddr, req_way, rd_ack, rd_valid, rd_data,
        input  req_ready, rd_req, rd_addr, rd_len, data_addr, data_din, data_we,
               tag_addr, vl_addr, tag_din, vl_din, tag_we, vl_we, refill_done, init_busy
`ifdef REFILL_EARLY_FWD_EN
               , fwd_valid, fwd_data
`endif
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache line refill engine: post-reset tag/valid sweep, 8-beat line fetch, tag+valid commit.
// Optional critical-word forwarding enabled by defining REFILL_EARLY_FWD_EN.
module cache_refill_ctrl #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 20,
    parameter int WORDS   = 8
) (
    input  logic           clk,
    input  logic           rstn,
    cache_refill_if.master bus
);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BEAT_W = $clog2(WORDS);
    localparam int OFF_W  = BEAT_W + 2;
    localparam int LINE_W = 32 - OFF_W;
    localparam int SEL_W  = $clog2(WAYS * WORDS);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REQ,
        S_RECV,
        S_COMMIT
    } state_t;

    state_t                state;
    logic [INDEX_W-1:0]    sweep_cnt;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [LINE_W-1:0]     line_q;
    logic [WAY_W-1:0]      way_q;

    logic [INDEX_W-1:0]    line_idx;
    logic [TAG_W-1:0]      line_tag;
    logic [WAYS-1:0]       way_oh;
    logic [SEL_W-1:0]      bank_sel;
    logic                  beat_we;
    logic                  sweep_we;
    logic                  commit_we;
    logic                  unused_addr_bits;

    // Control only; the latched line address and way carry no reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_INIT;
            sweep_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == {INDEX_W{1'b1}})
                        state <= S_IDLE;
                end
                S_IDLE: begin
                    if (bus.req_valid) begin
                        line_q <= bus.req_paddr[31:OFF_W];
                        way_q  <= bus.req_way;
                        state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.rd_ack)
                        state <= S_RECV;
                end
                S_RECV: begin
                    if (bus.rd_valid) begin
                        if (beat_cnt == BEAT_W'(WORDS - 1)) begin
                            beat_cnt <= '0;
                            state    <= S_COMMIT;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: state <= S_IDLE;
                default:  state <= S_INIT;
            endcase
        end
    end

    assign line_idx = line_q[INDEX_W-1:0];
    assign line_tag = line_q[LINE_W-1 -: TAG_W];
    assign way_oh   = {{(WAYS-1){1'b0}}, 1'b1} << way_q;
    assign bank_sel = SEL_W'(way_q) * SEL_W'(WORDS) + SEL_W'(beat_cnt);

    // Every strobe is masked while rstn is low so a reset cycle never writes a bank.
    assign beat_we   = rstn && (state == S_RECV) && bus.rd_valid;
    assign sweep_we  = rstn && (state == S_INIT);
    assign commit_we = rstn && (state == S_COMMIT);

    assign bus.req_ready   = rstn && (state == S_IDLE);
    assign bus.rd_req      = rstn && (state == S_REQ);
    assign bus.rd_addr     = {line_q, {OFF_W{1'b0}}};
    assign bus.rd_len      = 8'(WORDS - 1);

    assign bus.data_addr   = line_idx;
    assign bus.data_din    = bus.rd_data;
    assign bus.data_we     = beat_we ? ({{(WAYS*WORDS-1){1'b0}}, 1'b1} << bank_sel) : '0;

    assign bus.tag_addr    = (state == S_INIT) ? sweep_cnt : line_idx;
    assign bus.vl_addr     = (state == S_INIT) ? sweep_cnt : line_idx;
    assign bus.tag_din     = (state == S_COMMIT) ? line_tag : '0;
    assign bus.vl_din      = (state == S_COMMIT);
    assign bus.tag_we      = sweep_we ? {WAYS{1'b1}} : (commit_we ? way_oh : '0);
    assign bus.vl_we       = sweep_we ? {WAYS{1'b1}} : (commit_we ? way_oh : '0);

    assign bus.refill_done = commit_we;
    assign bus.init_busy   = (state == S_INIT);

`ifdef REFILL_EARLY_FWD_EN
    logic [BEAT_W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.req_valid)
            word_q <= bus.req_paddr[2 +: BEAT_W];
    end

    // Critical word goes to the core the same cycle it is written into the bank.
    assign bus.fwd_valid = beat_we && (beat_cnt == word_q);
    assign bus.fwd_data  = bus.rd_data;
`endif

    assign unused_addr_bits = ^bus.req_paddr[OFF_W-1:0];
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: reset sweep, refills with gaps, late ack, mid-line reset.
// Forwarding checks compile in only when REFILL_EARLY_FWD_EN is defined.
module tb_cache_refill_ctrl;
    localparam int WAYS    = 2;
    localparam int INDEX_W = 7;
    localparam int TAG_W   = 20;
    localparam int WORDS   = 8;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cache_refill_if #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .WORDS(WORDS)) bus ();

    cache_refill_ctrl #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .WORDS(WORDS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts in the first post-reset cycle (rstn already high, settled before the next edge).
    task automatic sweep(input bit stray);
        for (int k = 0; k < 128; k++) begin
            bus.rd_valid = stray;
            bus.rd_data  = 32'hDEAD_0000 + 32'(k);
            #1;
            check("sweep_ctl", {bus.init_busy, bus.req_ready, bus.vl_we, bus.tag_we, bus.vl_din,
                                bus.vl_addr, bus.tag_addr},
                               {1'b1, 1'b0, 2'b11, 2'b11, 1'b0, 7'(k), 7'(k)});
            check("sweep_quiet", {bus.tag_din, bus.data_we, bus.rd_req, bus.refill_done}, '0);
            @(negedge clk);
        end
        bus.rd_valid = 1'b0;
        #1;
        check("sweep_end", {bus.init_busy, bus.req_ready, bus.vl_we, bus.tag_we},
                           {1'b0, 1'b1, 2'b00, 2'b00});
    endtask

    task automatic run_line(input logic [31:0] pa, input int way, input int ack_dly,
                            input bit gaps, input bit stray, input int abort_at,
                            input logic [31:0] exp_addr, input logic [6:0] exp_idx,
                            input logic [19:0] exp_tag, input int exp_word);
        logic [31:0] d;
        logic [1:0]  exp_oh;
        bit          gap;
        int          k;
        int          c;
        exp_oh = (way == 1) ? 2'b10 : 2'b01;

        bus.req_paddr = pa;
        bus.req_way   = 1'(way);
        bus.req_valid = 1'b1;
        #1;
        check("req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_paddr = ~pa;

        for (int i = 0; i <= ack_dly; i++) begin
            bus.rd_ack   = (i == ack_dly);
            bus.rd_valid = stray;
            bus.rd_data  = 32'hBAD0_0000 + 32'(i);
            #1;
            check("rd_req_held", {bus.rd_req, bus.req_ready}, 2'b10);
            check("rd_addr", bus.rd_addr, exp_addr);
            check("rd_len", bus.rd_len, 8'd7);
            check("no_we_before_ack", bus.data_we, '0);
            @(negedge clk);
        end
        bus.rd_ack = 1'b0;

        k = 0;
        c = 0;
        while (k < 8) begin
            if (k == abort_at) begin
                rstn         = 1'b0;
                bus.rd_valid = 1'b1;
                #1;
                check("abort_quiet", {bus.tag_we, bus.vl_we, bus.data_we, bus.refill_done}, '0);
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            gap          = gaps && (c % 2 == 1);
            d            = {pa[23:8], 16'h0A00 + 16'(k)};
            bus.rd_valid = !gap;
            bus.rd_data  = d;
            #1;
            if (gap) begin
                check("gap_quiet", bus.data_we, '0);
            end else begin
                check("beat_we", bus.data_we, 64'(1) << (way * 8 + k));
                check("beat_addr", bus.data_addr, exp_idx);
                check("beat_din", bus.data_din, d);
            end
            check("no_early_commit", {bus.tag_we, bus.vl_we, bus.refill_done}, '0);
`ifdef REFILL_EARLY_FWD_EN
            check("fwd_valid", bus.fwd_valid, (!gap && k == exp_word));
            if (!gap && k == exp_word)
                check("fwd_data", bus.fwd_data, d);
`endif
            @(negedge clk);
            if (!gap)
                k++;
            c++;
        end

        bus.rd_valid = stray;
        #1;
        check("commit_we", {bus.tag_we, bus.vl_we}, {exp_oh, exp_oh});
        check("commit_data", {bus.tag_din, bus.vl_din, bus.tag_addr, bus.vl_addr},
                             {exp_tag, 1'b1, exp_idx, exp_idx});
        check("refill_done", bus.refill_done, 1'b1);
        check("commit_no_data", bus.data_we, '0);
        @(negedge clk);
        bus.rd_valid = 1'b0;
        #1;
        check("done_pulse", {bus.refill_done, bus.tag_we, bus.vl_we, bus.req_ready},
                            {1'b0, 2'b00, 2'b00, 1'b1});
    endtask

    initial begin
        rstn          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_paddr = '0;
        bus.req_way   = '0;
        bus.rd_ack    = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_quiet", {bus.req_ready, bus.rd_req, bus.refill_done, bus.tag_we, bus.vl_we,
                              bus.data_we}, '0);
        @(negedge clk);
        rstn = 1'b1;
        sweep(1'b0);

        // Basic refill into way 1.
        run_line(32'h1234_5678, 1, 0, 1'b0, 1'b0, 99, 32'h1234_5660, 7'h33, 20'h12345, 6);
        // Beats every other cycle into way 0, top set.
        run_line(32'hABCD_EFE4, 0, 0, 1'b1, 1'b0, 99, 32'hABCD_EFE0, 7'h7F, 20'hABCDE, 1);
        // Ack delayed 5 cycles with stray rd_valid outside the beat window.
        run_line(32'h8000_0018, 0, 5, 1'b0, 1'b1, 99, 32'h8000_0000, 7'h00, 20'h80000, 6);
        // Reset after beat 3: no commit, sweep restarts while late beats keep arriving.
        run_line(32'h0000_1040, 1, 0, 1'b0, 1'b0, 4, 32'h0000_1040, 7'h02, 20'h00001, 0);
        sweep(1'b1);
        run_line(32'h0000_1040, 1, 0, 1'b0, 1'b0, 99, 32'h0000_1040, 7'h02, 20'h00001, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
